// File: rtl/dsp_issue_scheduler.sv
// Round-robin issue scheduler sharing one DSP MAC slice between two requesters.
// Optional MAC-chain grant lock is enabled with `define DSP_SCHED_MAC_LOCK_EN.
module dsp_issue_scheduler #(
  parameter int WIDTH         = 16,
  parameter int SHIFT_BITS    = 2,
  parameter int PIPELINE_BITS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*WIDTH-1:0]         req_aa,
  input  logic [2*WIDTH-1:0]         req_bb,
  input  logic [4*WIDTH-1:0]         req_cc,
  input  logic [3:0]                 req_mode,
  input  logic [1:0]                 req_mac,
  input  logic [1:0]                 req_last,
  input  logic [2*SHIFT_BITS-1:0]    req_shift_amount,
  input  logic [1:0]                 req_shift_dir,
  input  logic [PIPELINE_BITS-1:0]   cfg_pipe_stages,
  output logic                       dsp_start,
  output logic                       dsp_mac,
  output logic                       dsp_shift_dir,
  output logic [1:0]                 dsp_mode,
  output logic [SHIFT_BITS-1:0]      dsp_shift_amount,
  output logic [PIPELINE_BITS-1:0]   dsp_pipe_stages,
  output logic [WIDTH-1:0]           dsp_aa,
  output logic [WIDTH-1:0]           dsp_bb,
  output logic [2*WIDTH-1:0]         dsp_cc,
  input  logic [2*WIDTH-1:0]         dsp_out,
  output logic                       rsp_valid,
  output logic                       rsp_id,
  output logic [2*WIDTH-1:0]         rsp_data,
  output logic                       busy,
  output logic                       err_mode
);

  localparam int TAG_DEPTH = PIPELINE_BITS + 2;
  localparam logic [PIPELINE_BITS-1:0] PIPE_MAX = PIPELINE_BITS'(PIPELINE_BITS);

  logic                     ptr_q, ptr_d;
  logic                     dsp_start_q, dsp_start_d;
  logic                     dsp_mac_q, dsp_mac_d;
  logic                     dsp_shift_dir_q, dsp_shift_dir_d;
  logic [1:0]               dsp_mode_q, dsp_mode_d;
  logic [SHIFT_BITS-1:0]    dsp_shift_amount_q, dsp_shift_amount_d;
  logic [PIPELINE_BITS-1:0] dsp_pipe_stages_q, dsp_pipe_stages_d;
  logic [WIDTH-1:0]         dsp_aa_q, dsp_aa_d, dsp_bb_q, dsp_bb_d;
  logic [2*WIDTH-1:0]       dsp_cc_q, dsp_cc_d;
  logic                     rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic                     err_mode_q, err_mode_d;
  logic [TAG_DEPTH-1:0]     tag_valid_q, tag_valid_d, tag_id_q, tag_id_d;

  logic [PIPELINE_BITS-1:0] pipe_sel;
  logic                     idle, pipe_conflict, accept, issue, win_id;
  logic [1:0]               mode_conflict, elig, grant, lock_ok, sel_mode;
  logic                     mac_en;

`ifdef DSP_SCHED_MAC_LOCK_EN
  logic lock_q, lock_d, lock_id_q, lock_id_d;
  logic sel_mac, sel_last;

  assign lock_ok  = lock_q ? {lock_id_q, ~lock_id_q} : 2'b11;
  assign sel_mac  = win_id ? req_mac[1]  : req_mac[0];
  assign sel_last = win_id ? req_last[1] : req_last[0];
  assign mac_en   = sel_mac;

  // A chain holds the grant from its first non-last mac op until its last op.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      if (sel_last) begin
        lock_d = 1'b0;
      end else if (sel_mac) begin
        lock_d    = 1'b1;
        lock_id_d = win_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  logic unused_mac_inputs;
  assign unused_mac_inputs = ^{req_mac, req_last};
  assign lock_ok = 2'b11;
  assign mac_en  = 1'b0;
`endif

  always_comb begin
    pipe_sel      = (cfg_pipe_stages > PIPE_MAX) ? PIPE_MAX : cfg_pipe_stages;
    idle          = ~|tag_valid_q;
    pipe_conflict = (pipe_sel != dsp_pipe_stages_q) && !idle;
    for (int i = 0; i < 2; i++) begin
      mode_conflict[i] = (req_mode[2*i +: 2] != 2'b11) &&
                         (req_mode[2*i +: 2] != dsp_mode_q) && !idle;
      elig[i] = req_valid[i] & ~mode_conflict[i] & ~pipe_conflict & lock_ok[i];
    end
    if (elig == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    else               grant = elig;
    accept   = |grant;
    win_id   = grant[1];
    sel_mode = win_id ? req_mode[3:2] : req_mode[1:0];
    issue    = accept && (sel_mode != 2'b11);

    ptr_d              = accept ? ~win_id : ptr_q;
    err_mode_d         = err_mode_q | (accept && (sel_mode == 2'b11));
    dsp_start_d        = issue;
    dsp_mac_d          = issue & mac_en;
    dsp_aa_d           = '0;
    dsp_bb_d           = '0;
    dsp_cc_d           = '0;
    dsp_mode_d         = dsp_mode_q;
    dsp_shift_amount_d = dsp_shift_amount_q;
    dsp_shift_dir_d    = dsp_shift_dir_q;
    if (issue) begin
      dsp_aa_d           = win_id ? req_aa[WIDTH +: WIDTH] : req_aa[0 +: WIDTH];
      dsp_bb_d           = win_id ? req_bb[WIDTH +: WIDTH] : req_bb[0 +: WIDTH];
      dsp_cc_d           = win_id ? req_cc[2*WIDTH +: 2*WIDTH] : req_cc[0 +: 2*WIDTH];
      dsp_mode_d         = sel_mode;
      dsp_shift_amount_d = win_id ? req_shift_amount[SHIFT_BITS +: SHIFT_BITS]
                                  : req_shift_amount[0 +: SHIFT_BITS];
      dsp_shift_dir_d    = win_id ? req_shift_dir[1] : req_shift_dir[0];
    end
    dsp_pipe_stages_d = idle ? pipe_sel : dsp_pipe_stages_q;

    // Tags retire at the stage matching the active depth so the count stays exact.
    tag_valid_d[0] = issue;
    tag_id_d[0]    = win_id;
    for (int k = 1; k < TAG_DEPTH; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1] && ((k - 1) < int'(dsp_pipe_stages_q));
      tag_id_d[k]    = tag_id_q[k-1];
    end
    rsp_valid_d = tag_valid_q[dsp_pipe_stages_q];
    rsp_id_d    = tag_id_q[dsp_pipe_stages_q];
    rsp_data_d  = dsp_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q              <= 1'b0;
      dsp_start_q        <= 1'b0;
      dsp_mac_q          <= 1'b0;
      dsp_shift_dir_q    <= 1'b0;
      dsp_mode_q         <= '0;
      dsp_shift_amount_q <= '0;
      dsp_pipe_stages_q  <= '0;
      dsp_aa_q           <= '0;
      dsp_bb_q           <= '0;
      dsp_cc_q           <= '0;
      rsp_valid_q        <= 1'b0;
      rsp_id_q           <= 1'b0;
      rsp_data_q         <= '0;
      err_mode_q         <= 1'b0;
      tag_valid_q        <= '0;
      tag_id_q           <= '0;
    end else begin
      ptr_q              <= ptr_d;
      dsp_start_q        <= dsp_start_d;
      dsp_mac_q          <= dsp_mac_d;
      dsp_shift_dir_q    <= dsp_shift_dir_d;
      dsp_mode_q         <= dsp_mode_d;
      dsp_shift_amount_q <= dsp_shift_amount_d;
      dsp_pipe_stages_q  <= dsp_pipe_stages_d;
      dsp_aa_q           <= dsp_aa_d;
      dsp_bb_q           <= dsp_bb_d;
      dsp_cc_q           <= dsp_cc_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_id_q           <= rsp_id_d;
      rsp_data_q         <= rsp_data_d;
      err_mode_q         <= err_mode_d;
      tag_valid_q        <= tag_valid_d;
      tag_id_q           <= tag_id_d;
    end
  end

  assign req_ready        = grant;
  assign dsp_start        = dsp_start_q;
  assign dsp_mac          = dsp_mac_q;
  assign dsp_shift_dir    = dsp_shift_dir_q;
  assign dsp_mode         = dsp_mode_q;
  assign dsp_shift_amount = dsp_shift_amount_q;
  assign dsp_pipe_stages  = dsp_pipe_stages_q;
  assign dsp_aa           = dsp_aa_q;
  assign dsp_bb           = dsp_bb_q;
  assign dsp_cc           = dsp_cc_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_id           = rsp_id_q;
  assign rsp_data         = rsp_data_q;
  assign busy             = |tag_valid_q;
  assign err_mode         = err_mode_q;

endmodule
